// File: rtl/sys_seq.sv
// Power-up sequencer: walks NUM_STAGES init engines in order, then releases the TX chain.
// Latency: init strobe follows state by 0 cycles; tx_rst_o/dev_conf_active_o drop 1 cycle after RUN entry.
// Backpressure: none; each stage is paced by its done level, bounded by a per-attempt timeout.
//
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   restart_i            - restart pulse, honoured only in RUN or ERROR
//   stage_done_i         - per-stage done levels from the init engines
//   stage_init_o         - one-hot init request for the active stage (INIT only)
//   stage_idx_o          - current stage, or the failing stage while in ERROR
//   retry_cnt_o          - retries consumed on the current stage
//   err_o                - sticky sequence failure
//   dev_conf_active_o    - high while configuring (IDLE/GAP/INIT)
//   tx_rst_o             - TX chain reset, low only in RUN
module sys_seq #(
    parameter int NUM_STAGES     = 2,
    parameter int TIMEOUT_W      = 24,
    parameter int TIMEOUT_CYCLES = 10000000,
    parameter int MAX_RETRY      = 2,
    parameter int START_DELAY    = 4,
    localparam int SW            = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart_i,
    input  logic [NUM_STAGES-1:0] stage_done_i,
    output logic [NUM_STAGES-1:0] stage_init_o,
    output logic [SW-1:0]         stage_idx_o,
    output logic [3:0]            retry_cnt_o,
    output logic                  err_o,
    output logic                  dev_conf_active_o,
    output logic                  tx_rst_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [SW-1:0]        LAST_IDX  = SW'(NUM_STAGES - 1);
    localparam logic [7:0]           DLY_LAST  = 8'(START_DELAY);
    localparam logic [3:0]           RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST  =
        TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic                 TMO_EN    = (TIMEOUT_CYCLES != 0);

    logic [2:0]           state_q, state_d;
    logic [SW-1:0]        idx_q, idx_d;
    logic [3:0]           retry_q, retry_d;
    logic [7:0]           dly_q, dly_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 err_q, err_d;
    logic                 tx_rst_q, tx_rst_d;
    logic                 conf_q, conf_d;

    logic restart_ok;
    logic done_hit;
    logic tmo_hit;
    logic running;

    assign restart_ok = restart_i && ((state_q == S_RUN) || (state_q == S_ERROR));
    assign done_hit   = stage_done_i[idx_q];
    assign tmo_hit    = TMO_EN && (tmo_q == TMO_LAST);
    // Stays true for every RUN cycle that is not being left via restart.
    assign running    = (state_q == S_RUN) && !restart_ok;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        dly_d   = dly_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (dly_q == DLY_LAST) begin
                    state_d = S_INIT;
                    idx_d   = '0;
                    retry_d = '0;
                end else begin
                    dly_d = dly_q + 8'd1;
                end
            end
            S_INIT: begin
                // Done has priority over a coincident timeout.
                if (done_hit) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_GAP;
                        idx_d   = idx_q + SW'(1);
                        retry_d = '0;
                    end
                end else if (tmo_hit) begin
                    if (retry_q < RETRY_MAX) begin
                        state_d = S_GAP;
                        retry_d = retry_q + 4'd1;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_GAP: state_d = S_INIT;
            S_RUN, S_ERROR: begin
                if (restart_i) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    retry_d = '0;
                    dly_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter runs only across consecutive INIT cycles of one attempt.
    assign tmo_d    = ((state_q == S_INIT) && (state_d == S_INIT)) ? tmo_q + TIMEOUT_W'(1) : '0;
    // Registered off the current state so both drop one cycle after RUN entry,
    // while ERROR deasserts conf immediately.
    assign tx_rst_d = !running;
    assign conf_d   = (state_d != S_ERROR) && !running;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            retry_q  <= '0;
            dly_q    <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            tx_rst_q <= 1'b1;
            conf_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            dly_q    <= dly_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            tx_rst_q <= tx_rst_d;
            conf_q   <= conf_d;
        end
    end

    assign stage_init_o      = (state_q == S_INIT) ? (NUM_STAGES'(1) << idx_q) : '0;
    assign stage_idx_o       = idx_q;
    assign retry_cnt_o       = retry_q;
    assign err_o             = err_q;
    assign dev_conf_active_o = conf_q;
    assign tx_rst_o          = tx_rst_q;

endmodule

// File: tb/tb_sys_seq.sv
module tb_sys_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       restart_i = 1'b0;
    logic [2:0] stage_done_i = '0;
    logic [2:0] stage_init_o;
    logic [1:0] stage_idx_o;
    logic [3:0] retry_cnt_o;
    logic       err_o;
    logic       dev_conf_active_o;
    logic       tx_rst_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sys_seq #(
        .NUM_STAGES    (3),
        .TIMEOUT_W     (24),
        .TIMEOUT_CYCLES(16),
        .MAX_RETRY     (1),
        .START_DELAY   (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .restart_i        (restart_i),
        .stage_done_i     (stage_done_i),
        .stage_init_o     (stage_init_o),
        .stage_idx_o      (stage_idx_o),
        .retry_cnt_o      (retry_cnt_o),
        .err_o            (err_o),
        .dev_conf_active_o(dev_conf_active_o),
        .tx_rst_o         (tx_rst_o)
    );

    typedef struct {
        logic       rs;
        logic [2:0] dn;
        logic [2:0] e_init;
        logic [1:0] e_idx;
        logic [3:0] e_retry;
        logic       e_err;
        logic       e_conf;
        logic       e_tx;
    } vec_t;

    vec_t vecs[$];

    task automatic add_n(input int n, input logic rs, input logic [2:0] dn, input logic [2:0] ini,
                         input logic [1:0] idx, input logic [3:0] rt, input logic er,
                         input logic cf, input logic tx);
        vec_t v;
        v.rs = rs; v.dn = dn; v.e_init = ini; v.e_idx = idx;
        v.e_retry = rt; v.e_err = er; v.e_conf = cf; v.e_tx = tx;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] ini, input logic [1:0] idx,
                             input logic [3:0] rt, input logic er, input logic cf, input logic tx);
        chk({tag, ".init"},  32'(stage_init_o),      32'(ini));
        chk({tag, ".idx"},   32'(stage_idx_o),       32'(idx));
        chk({tag, ".retry"}, 32'(retry_cnt_o),       32'(rt));
        chk({tag, ".err"},   32'(err_o),             32'(er));
        chk({tag, ".conf"},  32'(dev_conf_active_o), 32'(cf));
        chk({tag, ".txrst"}, 32'(tx_rst_o),          32'(tx));
    endtask

    // Inputs change at negedge, outputs are sampled 1 time unit after the posedge.
    task automatic step(input logic rs, input logic [2:0] dn);
        @(negedge clk);
        restart_i    = rs;
        stage_done_i = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n, input logic [2:0] dn);
        for (int i = 0; i < n; i++) step(1'b0, dn);
    endtask

    // Release lands mid-cycle so the next step's edge is the first edge after release.
    task automatic do_reset(input string tag);
        rst          = 1'b1;
        restart_i    = 1'b0;
        stage_done_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_out(tag, 3'b000, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Nominal bring-up, stale done bits on finished stages, RUN, restart from RUN.
        add_n(2, 0, 3'b000, 3'b000, 2'd0, 0, 0, 1, 1);
        add_n(1, 0, 3'b000, 3'b001, 2'd0, 0, 0, 1, 1);
        add_n(4, 0, 3'b000, 3'b001, 2'd0, 0, 0, 1, 1);
        add_n(1, 0, 3'b001, 3'b000, 2'd1, 0, 0, 1, 1);
        add_n(5, 0, 3'b001, 3'b010, 2'd1, 0, 0, 1, 1);
        add_n(1, 0, 3'b011, 3'b000, 2'd2, 0, 0, 1, 1);
        add_n(5, 0, 3'b011, 3'b100, 2'd2, 0, 0, 1, 1);
        add_n(1, 0, 3'b111, 3'b000, 2'd2, 0, 0, 1, 1);
        add_n(1, 0, 3'b111, 3'b000, 2'd2, 0, 0, 0, 0);
        add_n(2, 0, 3'b000, 3'b000, 2'd2, 0, 0, 0, 0);
        add_n(1, 1, 3'b000, 3'b000, 2'd0, 0, 0, 1, 1);
        add_n(2, 0, 3'b000, 3'b000, 2'd0, 0, 0, 1, 1);
        add_n(1, 0, 3'b000, 3'b001, 2'd0, 0, 0, 1, 1);

        do_reset("rst0");
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rs, vecs[i].dn);
            check_out($sformatf("vec%0d", i), vecs[i].e_init, vecs[i].e_idx, vecs[i].e_retry,
                      vecs[i].e_err, vecs[i].e_conf, vecs[i].e_tx);
        end

        // Stage 1 times out once, succeeds on retry; stage 2 done on the exact timeout cycle.
        do_reset("rst1");
        steps(3, 3'b000);
        check_out("t2.s0", 3'b001, 2'd0, 4'd0, 0, 1, 1);
        step(0, 3'b001);
        check_out("t2.gap0", 3'b000, 2'd1, 4'd0, 0, 1, 1);
        step(0, 3'b000);
        steps(15, 3'b000);
        check_out("t2.att1_end", 3'b010, 2'd1, 4'd0, 0, 1, 1);
        step(0, 3'b000);
        check_out("t2.retry_gap", 3'b000, 2'd1, 4'd1, 0, 1, 1);
        step(0, 3'b000);
        check_out("t2.att2", 3'b010, 2'd1, 4'd1, 0, 1, 1);
        steps(3, 3'b000);
        step(0, 3'b010);
        check_out("t2.adv", 3'b000, 2'd2, 4'd0, 0, 1, 1);
        step(0, 3'b000);
        check_out("t5.s2", 3'b100, 2'd2, 4'd0, 0, 1, 1);
        steps(15, 3'b000);
        check_out("t5.pre", 3'b100, 2'd2, 4'd0, 0, 1, 1);
        step(0, 3'b100);
        check_out("t5.run", 3'b000, 2'd2, 4'd0, 0, 1, 1);
        step(0, 3'b100);
        check_out("t5.txrel", 3'b000, 2'd2, 4'd0, 0, 0, 0);

        // Restart from RUN, ignored restart mid-INIT, stage 2 exhausts retries.
        step(1, 3'b000);
        check_out("t3.idle", 3'b000, 2'd0, 4'd0, 0, 1, 1);
        steps(3, 3'b000);
        check_out("t3.s0", 3'b001, 2'd0, 4'd0, 0, 1, 1);
        step(1, 3'b000);
        check_out("t4.ign", 3'b001, 2'd0, 4'd0, 0, 1, 1);
        step(0, 3'b001);
        step(0, 3'b000);
        check_out("t3.s1", 3'b010, 2'd1, 4'd0, 0, 1, 1);
        step(0, 3'b010);
        step(0, 3'b000);
        check_out("t3.s2a", 3'b100, 2'd2, 4'd0, 0, 1, 1);
        steps(16, 3'b000);
        check_out("t3.gap", 3'b000, 2'd2, 4'd1, 0, 1, 1);
        step(0, 3'b000);
        check_out("t3.s2b", 3'b100, 2'd2, 4'd1, 0, 1, 1);
        steps(15, 3'b000);
        check_out("t3.s2b_end", 3'b100, 2'd2, 4'd1, 0, 1, 1);
        step(0, 3'b000);
        check_out("t3.err", 3'b000, 2'd2, 4'd1, 1, 0, 1);
        steps(20, 3'b111);
        check_out("t3.hold", 3'b000, 2'd2, 4'd1, 1, 0, 1);

        // Restart from ERROR, then a rerun with all done bits held high.
        step(1, 3'b000);
        check_out("t4.idle", 3'b000, 2'd0, 4'd0, 0, 1, 1);
        steps(2, 3'b000);
        check_out("t4.dly", 3'b000, 2'd0, 4'd0, 0, 1, 1);
        step(0, 3'b000);
        check_out("t4.s0", 3'b001, 2'd0, 4'd0, 0, 1, 1);
        step(0, 3'b111);
        check_out("t4.g0", 3'b000, 2'd1, 4'd0, 0, 1, 1);
        step(0, 3'b111);
        check_out("t4.s1", 3'b010, 2'd1, 4'd0, 0, 1, 1);
        step(0, 3'b111);
        check_out("t4.g1", 3'b000, 2'd2, 4'd0, 0, 1, 1);
        step(0, 3'b111);
        check_out("t4.s2", 3'b100, 2'd2, 4'd0, 0, 1, 1);
        step(0, 3'b111);
        check_out("t4.run", 3'b000, 2'd2, 4'd0, 0, 1, 1);
        step(0, 3'b111);
        check_out("t4.txrel", 3'b000, 2'd2, 4'd0, 0, 0, 0);

        // Async reset in the middle of stage 1 INIT.
        do_reset("rst2");
        steps(3, 3'b000);
        step(0, 3'b001);
        step(0, 3'b000);
        check_out("t6.s1", 3'b010, 2'd1, 4'd0, 0, 1, 1);
        #2;
        rst = 1'b1;
        #1;
        check_out("t6.async", 3'b000, 2'd0, 4'd0, 0, 1, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        steps(2, 3'b000);
        check_out("t6.idle", 3'b000, 2'd0, 4'd0, 0, 1, 1);
        step(0, 3'b000);
        check_out("t6.s0", 3'b001, 2'd0, 4'd0, 0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
